ldtu_ofifo_read_ctrl: RTL and testbench
=======================================

Name: ldtu_ofifo_read_ctrl

Overview:
- Read-side scheduler for the LiTe-DTU Hamming-protected output FIFO.
- Divides CLK into fixed output word slots and decides, per slot, whether to emit a FIFO data word, an idle word (0xEAAAAAAA) or a sync word (0x5A5A5A5A).
- Drives the FIFO read_signal one cycle ahead of each slot so the decoded 32-bit word is present when the slot closes.
- Sits between the FIFO top and the serializer word interface.

Parameters:
- Nbits_32, 32: data word width.
- WORD_PERIOD, 4: CLK cycles per output slot; legal range is 2 to 16.
- SYNC_WORDS, 8: number of 0x5A5A5A5A words in one sync burst, at least 1.
- CNT_W, 16: width of the data-word counter.
- idle_patternEA, 32'hEAAAAAAA: idle word.
- idle_pattern5A, 32'h5A5A5A5A: sync word.

Ports:
- CLK  in  1  block clock.
- reset  in  1  asynchronous, active-low; 0 = reset.
- enable  in  1  readout enable, level.
- sync_req  in  1  single-cycle sync burst request.
- clear_status  in  1  single-cycle clear of sticky flags.
- empty_signal  in  1  FIFO empty.
- full_signal  in  1  FIFO full.
- fifo_data  in  Nbits_32  decoded FIFO word, valid the cycle after read_signal.
- read_signal  out  1  FIFO read strobe.
- data_out  out  Nbits_32  registered output word.
- data_valid  out  1  one-cycle pulse when data_out updates (slot close).
- sync_busy  out  1  high while the block is in SYNC.
- overflow_flag  out  1  sticky: full_signal was seen while not reading.
- word_count  out  CNT_W  number of FIFO data words emitted.

Behaviour:
- Reset values: read_signal=0, data_out=0xEAAAAAAA, data_valid=0, sync_busy=0, overflow_flag=0, word_count=0, slot counter=0, state=OFF, sync_pending=0.
- Slot counter: runs 0 to WORD_PERIOD-1 and wraps. It runs in every state once out of reset.
  - slot_pre: counter == WORD_PERIOD-2.
  - slot_end: counter == WORD_PERIOD-1.
- sync_req sets sync_pending on any cycle. sync_pending clears on entry to SYNC. Requests arriving while in SYNC are ignored.
- States and slot-end decisions (transitions take effect only at slot_end):
  - OFF: emit idle, no reads. Go to RUN if enable=1.
  - RUN: if sync_pending, go to SYNC. Else if enable=0, go to OFF. Else stay in RUN.
  - SYNC: emit sync words; a burst counter counts SYNC_WORDS slots. After the last one, go to RUN if enable=1, else OFF. enable=0 never truncates a burst.
- Read issue: at slot_pre, read_signal=1 for exactly one cycle if and only if:
  - state==RUN, and
  - sync_pending==0 (sampled at slot_pre), and
  - enable==1, and
  - empty_signal==0.
  A read_issued flag is registered alongside.
- Output at slot_end; data_valid=1 for that one cycle:
  - read_issued: data_out=fifo_data, word_count+1 (wraps modulo 2^CNT_W).
  - else in SYNC, or the slot in which RUN→SYNC is decided: data_out=0x5A5A5A5A.
  - else: data_out=0xEAAAAAAA.
- sync_req landing between slot_pre and slot_end: the already-issued read still emits data in this slot; SYNC starts at the following slot.
- Simultaneous sync_req and non-empty FIFO at slot_pre: sync wins and no read is issued.
- overflow_flag sets on any cycle with full_signal=1 and read_signal=0. clear_status clears it; if set and clear are in the same cycle, set wins.
- Reset asserted mid-slot or mid-burst: all state returns asynchronously to reset values. The first slot_end after release occurs WORD_PERIOD cycles later.

Optional Feature:
- LDTU_RDCTRL_TMR_EN defined:
  - FSM state, slot counter and burst counter are triplicated and majority-voted each cycle, with in-place correction.
  - Extra output port tmrError (1 bit) = OR of voter mismatch flags.
- Not defined: single copy of each register, no tmrError port.

Decomposition:
- Package ldtu_ofifo_pkg holds:
  - idle/sync patterns
  - state encoding OFF=2'b00, RUN=2'b01, SYNC=2'b10
  - WORD_PERIOD legality check
- Sub-module ldtu_slot_timer: slot counter producing slot_pre/slot_end. It is triplicated under the TMR macro.

Test Plan:
1. Reset release, enable=1, FIFO empty → read_signal stays 0; data_valid every 4 cycles; data_out=0xEAAAAAAA; word_count=0.
2. FIFO preloaded with 0x00000001, 0x00000002, 0x00000003 → reads at slot_pre; data_out sequence 1,2,3 then 0xEAAAAAAA; word_count=3.
3. sync_req with FIFO non-empty → next slot starts 8 slots of 0x5A5A5A5A; sync_busy high for 32 cycles; FIFO words resume afterwards in order with none lost.
4. enable dropped during the 3rd sync word → burst completes all 8 words, then OFF emits idle with no reads.
5. full_signal held with enable=0 → overflow_flag=1; clear_status pulse clears it; clear during continued full keeps it at 1.
6. reset pulsed mid-burst at count 5 → all outputs return to reset values immediately; after release, first data_valid at cycle 4 and it is idle.

Source files
------------

// File: rtl/ldtu_ofifo_pkg.sv
// ldtu_ofifo_pkg: shared constants, state encoding and parameter checks for the output FIFO read controller
// Contents: idle/sync word patterns, slot counter width, FSM state encoding, WORD_PERIOD legality check.
package ldtu_ofifo_pkg;
    localparam logic [31:0] idle_patternEA = 32'hEAAAAAAA;
    localparam logic [31:0] idle_pattern5A = 32'h5A5A5A5A;
    localparam int SLOT_W = 4;
    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_RUN  = 2'b01,
        ST_SYNC = 2'b10
    } state_e;
    function automatic bit wp_legal(input int wp);
        return wp >= 2 && wp <= 16;
    endfunction
endpackage

// File: rtl/ldtu_slot_timer.sv
// ldtu_slot_timer: free-running output slot counter producing slot_pre / slot_end strobes
// Ports:
//   CLK, reset   clock, asynchronous active-low reset
//   cnt_i        current count (own register, or the voted value when triplicated)
//   cnt_q        this copy's count register
//   slot_pre     count == WORD_PERIOD-2, one cycle before the slot closes
//   slot_end     count == WORD_PERIOD-1, the slot-closing cycle
module ldtu_slot_timer
    import ldtu_ofifo_pkg::*;
#(
    parameter int WORD_PERIOD = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [SLOT_W-1:0] cnt_i,
    output logic [SLOT_W-1:0] cnt_q,
    output logic              slot_pre,
    output logic              slot_end
);
    logic [SLOT_W-1:0] cnt_d;

    always_comb begin
        slot_pre = cnt_i == SLOT_W'(WORD_PERIOD - 2);
        slot_end = cnt_i == SLOT_W'(WORD_PERIOD - 1);
        cnt_d    = slot_end ? '0 : cnt_i + 1'b1;
    end

    always_ff @(posedge CLK or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/ldtu_ofifo_read_ctrl.sv
// ldtu_ofifo_read_ctrl: read-side slot scheduler for the LiTe-DTU output FIFO (data / idle / sync words)
// Optional: define LDTU_RDCTRL_TMR_EN to triplicate state, slot and burst counters and add port tmrError.
// Ports:
//   CLK, reset        clock, asynchronous active-low reset
//   enable            readout enable (level)
//   sync_req          one-cycle request for a sync burst
//   clear_status      one-cycle clear of overflow_flag
//   empty_signal      FIFO empty
//   full_signal       FIFO full
//   fifo_data         decoded FIFO word, valid the cycle after read_signal
//   read_signal       FIFO read strobe, issued at slot_pre
//   data_out          registered output word
//   data_valid        one-cycle pulse at each slot close
//   sync_busy         high while in SYNC
//   overflow_flag     sticky: FIFO full while not reading
//   word_count        FIFO data words emitted (wraps)
//   tmrError          (TMR build only) OR of voter mismatches
module ldtu_ofifo_read_ctrl
    import ldtu_ofifo_pkg::*;
#(
    parameter int Nbits_32    = 32,
    parameter int WORD_PERIOD = 4,
    parameter int SYNC_WORDS  = 8,
    parameter int CNT_W       = 16
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                enable,
    input  logic                sync_req,
    input  logic                clear_status,
    input  logic                empty_signal,
    input  logic                full_signal,
    input  logic [Nbits_32-1:0] fifo_data,
    output logic                read_signal,
    output logic [Nbits_32-1:0] data_out,
    output logic                data_valid,
    output logic                sync_busy,
    output logic                overflow_flag,
    output logic [CNT_W-1:0]    word_count
`ifdef LDTU_RDCTRL_TMR_EN
    ,
    output logic                tmrError
`endif
);
    localparam int BW = SYNC_WORDS > 1 ? $clog2(SYNC_WORDS) : 1;

    if (!wp_legal(WORD_PERIOD) || SYNC_WORDS < 1) begin : g_bad_param
        $error("ldtu_ofifo_read_ctrl: WORD_PERIOD must be 2..16 and SYNC_WORDS >= 1");
    end

    state_e              state_q, state_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic [SLOT_W-1:0]   cnt_q;
    logic                slot_pre, slot_end, pend, to_sync, last;
    logic                sync_pending_q, sync_pending_d, read_issued_q, overflow_q, overflow_d, data_valid_q;
    logic [Nbits_32-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;

    always_comb begin
        // A request in the current cycle already counts, so a same-cycle request at slot_pre blocks the read
        pend           = sync_pending_q | sync_req;
        to_sync        = slot_end && state_q == ST_RUN && pend;
        last           = state_q == ST_SYNC && burst_q == BW'(SYNC_WORDS - 1);
        read_signal    = slot_pre && state_q == ST_RUN && !pend && enable && !empty_signal;
        state_d        = state_q;
        burst_d        = burst_q;
        if (slot_end) begin
            state_d = state_q == ST_OFF ? (enable ? ST_RUN : ST_OFF)
                    : state_q == ST_RUN ? (pend ? ST_SYNC : enable ? ST_RUN : ST_OFF)
                    : last ? (enable ? ST_RUN : ST_OFF) : ST_SYNC;
            burst_d = state_q == ST_SYNC ? burst_q + 1'b1 : '0;
        end
        // Entry into SYNC absorbs any request seen in the same cycle
        sync_pending_d = to_sync ? 1'b0 : (sync_req && state_q != ST_SYNC) ? 1'b1 : sync_pending_q;
        overflow_d     = (full_signal && !read_signal) ? 1'b1 : clear_status ? 1'b0 : overflow_q;
        data_out_d     = !slot_end ? data_out_q
                       : read_issued_q ? fifo_data
                       : (state_q == ST_SYNC || to_sync) ? Nbits_32'(idle_pattern5A)
                       : Nbits_32'(idle_patternEA);
        word_count_d   = word_count_q + CNT_W'(slot_end && read_issued_q);
    end

`ifdef LDTU_RDCTRL_TMR_EN
    logic [SLOT_W-1:0] cnt_r [3];
    state_e            state_r [3];
    logic [BW-1:0]     burst_r [3];
    logic [2:0]        pre_r, end_r;

    // Each copy advances from the voted value, so a single upset is repaired on the next edge
    for (genvar i = 0; i < 3; i++) begin : g_tmr
        ldtu_slot_timer #(.WORD_PERIOD(WORD_PERIOD)) u_slot_timer (
            .CLK     (CLK),
            .reset   (reset),
            .cnt_i   (cnt_q),
            .cnt_q   (cnt_r[i]),
            .slot_pre(pre_r[i]),
            .slot_end(end_r[i])
        );
        always_ff @(posedge CLK or negedge reset)
            if (!reset) begin
                state_r[i] <= ST_OFF;
                burst_r[i] <= '0;
            end else begin
                state_r[i] <= state_d;
                burst_r[i] <= burst_d;
            end
    end

    assign cnt_q    = (cnt_r[0] & cnt_r[1]) | (cnt_r[0] & cnt_r[2]) | (cnt_r[1] & cnt_r[2]);
    assign state_q  = state_e'((state_r[0] & state_r[1]) | (state_r[0] & state_r[2]) | (state_r[1] & state_r[2]));
    assign burst_q  = (burst_r[0] & burst_r[1]) | (burst_r[0] & burst_r[2]) | (burst_r[1] & burst_r[2]);
    assign slot_pre = (pre_r[0] & pre_r[1]) | (pre_r[0] & pre_r[2]) | (pre_r[1] & pre_r[2]);
    assign slot_end = (end_r[0] & end_r[1]) | (end_r[0] & end_r[2]) | (end_r[1] & end_r[2]);
    assign tmrError = cnt_r[0] != cnt_r[1] || cnt_r[1] != cnt_r[2]
                   || state_r[0] != state_r[1] || state_r[1] != state_r[2]
                   || burst_r[0] != burst_r[1] || burst_r[1] != burst_r[2];
`else
    ldtu_slot_timer #(.WORD_PERIOD(WORD_PERIOD)) u_slot_timer (
        .CLK     (CLK),
        .reset   (reset),
        .cnt_i   (cnt_q),
        .cnt_q   (cnt_q),
        .slot_pre(slot_pre),
        .slot_end(slot_end)
    );

    always_ff @(posedge CLK or negedge reset)
        if (!reset) begin
            state_q <= ST_OFF;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
`endif

    always_ff @(posedge CLK or negedge reset)
        if (!reset) begin
            sync_pending_q <= 1'b0;
            read_issued_q  <= 1'b0;
            overflow_q     <= 1'b0;
            data_out_q     <= Nbits_32'(idle_patternEA);
            data_valid_q   <= 1'b0;
            word_count_q   <= '0;
        end else begin
            sync_pending_q <= sync_pending_d;
            read_issued_q  <= read_signal;
            overflow_q     <= overflow_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= slot_end;
            word_count_q   <= word_count_d;
        end

    assign data_out      = data_out_q;
    assign data_valid    = data_valid_q;
    assign sync_busy     = state_q == ST_SYNC;
    assign overflow_flag = overflow_q;
    assign word_count    = word_count_q;
endmodule

// File: tb/tb_ldtu_ofifo_read_ctrl.sv
// tb_ldtu_ofifo_read_ctrl: scoreboard bench for the output FIFO read controller (WORD_PERIOD=4, SYNC_WORDS=8)
`timescale 1ns/1ps
module tb_ldtu_ofifo_read_ctrl;
    localparam logic [31:0] IDLE = 32'hEAAAAAAA;
    localparam logic [31:0] SYNC = 32'h5A5A5A5A;

    logic        CLK = 1'b0, reset = 1'b0, enable = 1'b0, sync_req = 1'b0, clear_status = 1'b0, full_signal = 1'b0;
    logic        empty_signal, read_signal, data_valid, sync_busy, overflow_flag;
    logic [31:0] fifo_data, data_out;
    logic [15:0] word_count;
    logic [31:0] mem [64];
    int          wr_ptr = 0, rd_ptr;
    int          checks = 0, errors = 0, n_reads = 0, busy_cnt = 0, base = 0;
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];

    ldtu_ofifo_read_ctrl dut (
        .CLK          (CLK),
        .reset        (reset),
        .enable       (enable),
        .sync_req     (sync_req),
        .clear_status (clear_status),
        .empty_signal (empty_signal),
        .full_signal  (full_signal),
        .fifo_data    (fifo_data),
        .read_signal  (read_signal),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .sync_busy    (sync_busy),
        .overflow_flag(overflow_flag),
        .word_count   (word_count)
    );

    always #5 CLK = ~CLK;

    assign empty_signal = rd_ptr == wr_ptr;

    always @(posedge CLK or negedge reset)
        if (!reset) begin
            rd_ptr    <= 0;
            fifo_data <= '0;
        end else if (read_signal) begin
            fifo_data <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
        end

    always @(negedge CLK) begin
        if (data_valid) got_q.push_back(data_out);
        if (read_signal) n_reads++;
        if (sync_busy) busy_cnt++;
    end

    task automatic start(input int n, input logic [31:0] first);
        @(negedge CLK);
        reset = 1'b0; enable = 1'b1; sync_req = 1'b0; clear_status = 1'b0; full_signal = 1'b0;
        for (int i = 0; i < n; i++) mem[i] = first + i;
        wr_ptr = n;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        base = got_q.size();
    endtask

    task automatic pulse_sync();
        sync_req = 1'b1;
        @(negedge CLK);
        sync_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        int r0;
        @(negedge CLK);
        reset = 1'b0; enable = 1'b1; wr_ptr = 0;
        #1;
        checks += 6;
        if (read_signal !== 1'b0) begin errors++; $display("FAIL rst_read got %b want 0", read_signal); end
        if (data_out !== IDLE) begin errors++; $display("FAIL rst_data got %h want %h", data_out, IDLE); end
        if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", data_valid); end
        if (sync_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", sync_busy); end
        if (overflow_flag !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow_flag); end
        if (word_count !== 16'd0) begin errors++; $display("FAIL rst_wc got %0d want 0", word_count); end
        @(negedge CLK);
        reset = 1'b1;
        base = got_q.size();
        r0 = n_reads;
        for (int i = 0; i < 5; i++) exp_q.push_back(IDLE);
        repeat (21) @(negedge CLK);
        #1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (base + i >= got_q.size() || got_q[base + i] !== e) begin
                errors++;
                $display("FAIL empty_word%0d got %h want %h", i, base + i < got_q.size() ? got_q[base + i] : 32'hx, e);
            end
        end
        checks += 2;
        if (n_reads - r0 != 0) begin errors++; $display("FAIL empty_reads got %0d want 0", n_reads - r0); end
        if (word_count !== 16'd0) begin errors++; $display("FAIL empty_wc got %0d want 0", word_count); end
    endtask

    task automatic test_fifo_words();
        logic [31:0] e;
        int r0;
        start(3, 32'h1);
        r0 = n_reads;
        exp_q.push_back(IDLE);
        for (int i = 1; i <= 3; i++) exp_q.push_back(i);
        repeat (2) exp_q.push_back(IDLE);
        repeat (25) @(negedge CLK);
        #1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (base + i >= got_q.size() || got_q[base + i] !== e) begin
                errors++;
                $display("FAIL data_word%0d got %h want %h", i, base + i < got_q.size() ? got_q[base + i] : 32'hx, e);
            end
        end
        checks += 2;
        if (n_reads - r0 != 3) begin errors++; $display("FAIL data_reads got %0d want 3", n_reads - r0); end
        if (word_count !== 16'd3) begin errors++; $display("FAIL data_wc got %0d want 3", word_count); end
    endtask

    task automatic test_sync_burst();
        logic [31:0] e;
        int b0;
        start(10, 32'h100);
        b0 = busy_cnt;
        exp_q.push_back(IDLE);
        exp_q.push_back(32'h100);
        repeat (9) exp_q.push_back(SYNC);
        for (int i = 1; i < 10; i++) exp_q.push_back(32'h100 + i);
        exp_q.push_back(IDLE);
        repeat (8) @(negedge CLK);
        pulse_sync();
        repeat (76) @(negedge CLK);
        #1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (base + i >= got_q.size() || got_q[base + i] !== e) begin
                errors++;
                $display("FAIL sync_word%0d got %h want %h", i, base + i < got_q.size() ? got_q[base + i] : 32'hx, e);
            end
        end
        checks += 2;
        if (busy_cnt - b0 != 32) begin errors++; $display("FAIL sync_busy_cycles got %0d want 32", busy_cnt - b0); end
        if (word_count !== 16'd10) begin errors++; $display("FAIL sync_wc got %0d want 10", word_count); end
    endtask

    task automatic test_sync_edges();
        logic [31:0] e;
        start(4, 32'h200);
        exp_q.push_back(IDLE);
        repeat (9) exp_q.push_back(SYNC);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + i);
        exp_q.push_back(IDLE);
        repeat (6) @(negedge CLK);
        pulse_sync();
        repeat (13) @(negedge CLK);
        pulse_sync();
        repeat (40) @(negedge CLK);
        #1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (base + i >= got_q.size() || got_q[base + i] !== e) begin
                errors++;
                $display("FAIL pre_word%0d got %h want %h", i, base + i < got_q.size() ? got_q[base + i] : 32'hx, e);
            end
        end
        checks++;
        if (word_count !== 16'd4) begin errors++; $display("FAIL pre_wc got %0d want 4", word_count); end
        start(4, 32'h300);
        exp_q.push_back(IDLE);
        exp_q.push_back(32'h300);
        repeat (8) exp_q.push_back(SYNC);
        for (int i = 1; i < 4; i++) exp_q.push_back(32'h300 + i);
        exp_q.push_back(IDLE);
        repeat (7) @(negedge CLK);
        pulse_sync();
        repeat (49) @(negedge CLK);
        #1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (base + i >= got_q.size() || got_q[base + i] !== e) begin
                errors++;
                $display("FAIL late_word%0d got %h want %h", i, base + i < got_q.size() ? got_q[base + i] : 32'hx, e);
            end
        end
        checks++;
        if (word_count !== 16'd4) begin errors++; $display("FAIL late_wc got %0d want 4", word_count); end
    endtask

    task automatic test_enable_drop();
        logic [31:0] e;
        int r0;
        start(4, 32'h400);
        r0 = n_reads;
        exp_q.push_back(IDLE);
        repeat (9) exp_q.push_back(SYNC);
        repeat (3) exp_q.push_back(IDLE);
        repeat (6) @(negedge CLK);
        pulse_sync();
        repeat (10) @(negedge CLK);
        enable = 1'b0;
        repeat (36) @(negedge CLK);
        #1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (base + i >= got_q.size() || got_q[base + i] !== e) begin
                errors++;
                $display("FAIL drop_word%0d got %h want %h", i, base + i < got_q.size() ? got_q[base + i] : 32'hx, e);
            end
        end
        checks += 3;
        if (n_reads - r0 != 0) begin errors++; $display("FAIL drop_reads got %0d want 0", n_reads - r0); end
        if (word_count !== 16'd0) begin errors++; $display("FAIL drop_wc got %0d want 0", word_count); end
        if (sync_busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b want 0", sync_busy); end
    endtask

    task automatic test_overflow();
        start(0, 32'h0);
        enable = 1'b0;
        full_signal = 1'b1;
        repeat (2) @(negedge CLK);
        full_signal = 1'b0;
        #1;
        checks++;
        if (overflow_flag !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow_flag); end
        @(negedge CLK);
        #1;
        checks++;
        if (overflow_flag !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow_flag); end
        clear_status = 1'b1;
        @(negedge CLK);
        clear_status = 1'b0;
        #1;
        checks++;
        if (overflow_flag !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow_flag); end
        full_signal = 1'b1;
        clear_status = 1'b1;
        @(negedge CLK);
        clear_status = 1'b0;
        #1;
        checks++;
        if (overflow_flag !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", overflow_flag); end
        full_signal = 1'b0;
        clear_status = 1'b1;
        @(negedge CLK);
        clear_status = 1'b0;
        #1;
        checks++;
        if (overflow_flag !== 1'b0) begin errors++; $display("FAIL ovf_clear2 got %b want 0", overflow_flag); end
    endtask

    task automatic test_reset_mid_burst();
        int first;
        start(4, 32'h500);
        repeat (7) @(negedge CLK);
        pulse_sync();
        repeat (22) @(negedge CLK);
        #1;
        checks += 2;
        if (sync_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", sync_busy); end
        if (word_count !== 16'd1) begin errors++; $display("FAIL mid_wc_before got %0d want 1", word_count); end
        reset = 1'b0;
        #1;
        checks += 5;
        if (sync_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", sync_busy); end
        if (word_count !== 16'd0) begin errors++; $display("FAIL mid_wc got %0d want 0", word_count); end
        if (data_out !== IDLE) begin errors++; $display("FAIL mid_data got %h want %h", data_out, IDLE); end
        if (data_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", data_valid); end
        if (read_signal !== 1'b0) begin errors++; $display("FAIL mid_read got %b want 0", read_signal); end
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        first = 0;
        for (int i = 1; i <= 12 && first == 0; i++) begin
            @(negedge CLK);
            #1;
            if (data_valid) first = i;
        end
        checks += 2;
        if (first != 4) begin errors++; $display("FAIL mid_first_valid got %0d want 4", first); end
        if (data_out !== IDLE) begin errors++; $display("FAIL mid_first_word got %h want %h", data_out, IDLE); end
    endtask

    initial begin
        test_reset();
        test_fifo_words();
        test_sync_burst();
        test_sync_edges();
        test_enable_drop();
        test_overflow();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
